inst_encoder: RTL and testbench

Streaming RISC-V instruction encoder. It is the inverse of the CPU's immediate generator. Each request carries an opcode, register fields and an immediate value, given in exactly the form the immediate generator outputs for that opcode. The block packs these into a 32-bit instruction word and emits it with an auto-incrementing byte address, ready to write into instruction memory (program loader, self-test stimulus). Illegal requests are consumed, counted and dropped.

---
 rtl/inst_encoder.sv | 149 ++++++++++++++
 tb/tb_inst_encoder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Streaming RISC-V instruction encoder (inverse of the CPU
//               immediate generator). Packs opcode, register fields and an
//               immediate into a 32-bit instruction word and emits it with an
//               auto-incrementing byte address. Illegal requests are consumed,
//               counted and dropped.
// Ports       : clk, rstn            - clock, async active-low reset
//               start, base_addr     - restart stream at aligned base_addr
//               in_valid/in_ready    - request handshake
//               in_opcode, in_rd, in_rs1, in_rs2, in_imm - request fields
//               out_valid/out_ready  - encoded word handshake
//               out_addr, out_inst   - byte address and instruction word
//               err, err_cnt         - sticky drop flag, saturating drop count
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_inst,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_beq   = 7'b1100011;
  localparam logic [6:0] c_op_lw    = 7'b0000011;
  localparam logic [6:0] c_op_sw    = 7'b0100011;
  localparam logic [6:0] c_op_addi  = 7'b0010011;
  localparam logic [6:0] c_op_auipc = 7'b0010111;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;

  localparam logic [ADDR_W-1:0] c_low_mask = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] c_step     = ADDR_W'(4);

  logic              r_valid;
  logic [31:0]       r_inst;
  // Address pointer; it is also the address of the word currently presented.
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [7:0]        r_cnt;

  logic              w_legal;
  logic [31:0]       w_inst;
  logic              w_accept;
  logic              w_out_hs;

  // Encoder and range check. Each immediate arrives in the form the immediate
  // generator produces, so the checks ensure the bits that are not encoded are
  // pure sign- or zero-extension and the round trip is exact.
  always_comb begin
    w_inst  = '0;
    w_legal = 1'b0;
    case (in_opcode)
      c_op_jal: begin
        w_inst  = {in_imm[19], in_imm[9:0], in_imm[10], in_imm[18:11], in_rd, in_opcode};
        w_legal = (in_imm[31:19] == {13{in_imm[19]}});
      end
      c_op_beq: begin
        w_inst  = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, 3'b000, in_imm[3:0], in_imm[10], in_opcode};
        w_legal = (in_imm[31:11] == {21{in_imm[11]}});
      end
      c_op_lw: begin
        w_inst  = {in_imm[11:0], in_rs1, 3'b010, in_rd, in_opcode};
        w_legal = (in_imm[31:12] == 20'd0);
      end
      c_op_sw: begin
        w_inst  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], in_opcode};
        w_legal = (in_imm[31:12] == 20'd0);
      end
      c_op_addi: begin
        w_inst  = {in_imm[11:0], in_rs1, 3'b000, in_rd, in_opcode};
        w_legal = (in_imm[31:11] == {21{in_imm[11]}});
      end
      c_op_auipc: begin
        w_inst  = {in_imm[31:12], in_rd, in_opcode};
        w_legal = (in_imm[11:0] == 12'd0);
      end
      c_op_jalr: begin
        w_inst  = {in_imm[11:0], in_rs1, 3'b000, in_rd, in_opcode};
        w_legal = (in_imm[31:12] == 20'd0);
      end
      default: begin
        w_inst  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  assign in_ready = !start && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_out_hs = r_valid && out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_addr  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (start) begin
      r_valid <= 1'b0;
      r_addr  <= base_addr & ~c_low_mask;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // Pointer advances on every consumed word; a word accepted in the same
      // cycle therefore lands on the advanced address with no bubble.
      if (w_out_hs) begin
        r_addr <= r_addr + c_step;
      end
      if (w_accept && w_legal) begin
        r_valid <= 1'b1;
        r_inst  <= w_inst;
      end else if (w_out_hs) begin
        r_valid <= 1'b0;
      end
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
        if (r_cnt != 8'hFF) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_inst  = r_inst;
  assign out_addr  = r_addr;
  assign err       = r_err;
  assign err_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Self-checking bench for inst_encoder. A behavioural model
//               tracks the word stream; a compare process checks the DUT on
//               every falling edge, and directed steps pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_inst;
  logic              err;
  logic [7:0]        err_cnt;

  int checks = 0;
  int errors = 0;

  inst_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_inst(out_inst), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_ADDI = 7'b0010011, OP_AUIPC = 7'b0010111,
                         OP_JALR = 7'b1100111, OP_BAD = 7'b0110011;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint unsigned fld(input logic [31:0] i, input int hi, input int lo);
    return (longint'(i) >> lo) % (64'd1 << (hi - lo + 1));
  endfunction

  function automatic bit ref_legal(input logic [6:0] op, input logic [31:0] i);
    int s;
    s = i;
    case (op)
      OP_JAL:                return (s >= -(1 << 19)) && (s < (1 << 19));
      OP_BEQ, OP_ADDI:       return (s >= -2048) && (s <= 2047);
      OP_LW, OP_SW, OP_JALR: return i < 32'd4096;
      OP_AUIPC:              return (i % 4096) == 0;
      default:               return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] i);
    longint unsigned w;
    w = op;
    case (op)
      OP_JAL:   w += rd * 128 + fld(i, 18, 11) * (1 << 12) + fld(i, 10, 10) * (1 << 20)
                     + fld(i, 9, 0) * (1 << 21) + fld(i, 19, 19) * (64'd1 << 31);
      OP_BEQ:   w += fld(i, 10, 10) * 128 + fld(i, 3, 0) * 256 + rs1 * (1 << 15)
                     + rs2 * (1 << 20) + fld(i, 9, 4) * (1 << 25) + fld(i, 11, 11) * (64'd1 << 31);
      OP_LW:    w += rd * 128 + 2 * (1 << 12) + rs1 * (1 << 15) + fld(i, 11, 0) * (1 << 20);
      OP_SW:    w += fld(i, 4, 0) * 128 + 2 * (1 << 12) + rs1 * (1 << 15) + rs2 * (1 << 20)
                     + fld(i, 11, 5) * (1 << 25);
      OP_ADDI, OP_JALR: w += rd * 128 + rs1 * (1 << 15) + fld(i, 11, 0) * (1 << 20);
      OP_AUIPC: w += rd * 128 + (i / 4096) * 4096;
      default:  w = 0;
    endcase
    return w[31:0];
  endfunction

  // Immediate generator: recovers the immediate from an instruction word.
  function automatic logic [31:0] immgen(input logic [6:0] op, input logic [31:0] x);
    case (op)
      OP_JAL:   return {{12{x[31]}}, x[31], x[19:12], x[20], x[30:21]};
      OP_BEQ:   return {{20{x[31]}}, x[31], x[7], x[30:25], x[11:8]};
      OP_ADDI:  return {{20{x[31]}}, x[31:20]};
      OP_LW, OP_JALR: return {20'd0, x[31:20]};
      OP_SW:    return {20'd0, x[31:25], x[11:7]};
      OP_AUIPC: return {x[31:12], 12'd0};
      default:  return 32'd0;
    endcase
  endfunction

  logic              m_valid;
  logic [31:0]       m_inst, m_imm;
  logic [6:0]        m_op;
  logic [ADDR_W-1:0] m_addr;
  logic              m_err;
  int                m_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0; m_inst <= '0; m_addr <= '0; m_err <= 1'b0; m_cnt <= 0;
      m_imm <= '0; m_op <= '0;
    end else if (start) begin
      m_valid <= 1'b0;
      m_addr  <= ADDR_W'((int'(base_addr) / 4) * 4);
      m_err   <= 1'b0;
      m_cnt   <= 0;
    end else begin
      automatic bit acc = in_valid && (!m_valid || out_ready);
      automatic bit nv  = m_valid && !out_ready;
      if (m_valid && out_ready) m_addr <= ADDR_W'((int'(m_addr) + 4) % (1 << ADDR_W));
      if (acc) begin
        if (ref_legal(in_opcode, in_imm)) begin
          nv = 1'b1;
          m_inst <= ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_imm);
          m_imm  <= in_imm;
          m_op   <= in_opcode;
        end else begin
          m_err <= 1'b1;
          m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end
      m_valid <= nv;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !start && (!m_valid || out_ready)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("err_cnt", {24'd0, err_cnt}, m_cnt);
      if (m_valid) begin
        chk("out_inst", out_inst, m_inst);
        chk("out_addr", {24'd0, out_addr}, {24'd0, m_addr});
        chk("round_trip", immgen(m_op, out_inst), m_imm);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    start = 1'b1; base_addr = base;
    #1 chk("start_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    start = 1'b0;
  endtask

  logic [6:0] ops [7] = '{OP_JAL, OP_BEQ, OP_LW, OP_SW, OP_ADDI, OP_AUIPC, OP_JALR};

  initial begin
    rstn = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    tick(); tick();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_inst", out_inst, 32'd0);
    chk("reset_out_addr", {24'd0, out_addr}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rstn = 1'b1;
    tick();

    // first word
    do_start(8'h10);
    req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    tick();
    in_valid = 1'b0;
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_inst", out_inst, 32'hFFF0_0093);
    chk("addi_addr", {24'd0, out_addr}, 32'h10);
    out_ready = 1'b1;
    tick();

    // back-to-back
    do_start(8'h10);
    req(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd4);
    tick();
    chk("jal_inst", out_inst, 32'h0080_00EF);
    chk("jal_addr", {24'd0, out_addr}, 32'h10);
    chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    req(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFE);
    tick();
    chk("beq_inst", out_inst, 32'hFE20_8EE3);
    chk("beq_addr", {24'd0, out_addr}, 32'h14);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    // illegal requests
    do_start(8'h10);
    req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    tick();
    req(OP_BAD, 5'd1, 5'd0, 5'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("ill_valid", {31'd0, out_valid}, 32'd0);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_cnt", {24'd0, err_cnt}, 32'd2);
    req(OP_LW, 5'd5, 5'd2, 5'd0, 32'd8);
    tick();
    in_valid = 1'b0;
    chk("lw_inst", out_inst, 32'h0081_2283);
    chk("lw_addr", {24'd0, out_addr}, 32'h10);
    tick();

    // backpressure
    do_start(8'h20);
    out_ready = 1'b0;
    req(OP_SW, 5'd0, 5'd2, 5'd5, 32'h10);
    tick();
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    chk("sw_inst", out_inst, 32'h0051_2823);
    req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    chk("bp_hold_inst", out_inst, 32'h0051_2823);
    chk("bp_hold_addr", {24'd0, out_addr}, 32'h20);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_inst", out_inst, 32'h0050_0093);
    chk("bp_second_addr", {24'd0, out_addr}, 32'h24);
    tick();

    // address wrap, unaligned base
    do_start(8'hFE);
    req(OP_AUIPC, 5'd3, 5'd0, 5'd0, 32'h1234_5000);
    tick();
    chk("wrap_inst0", out_inst, 32'h1234_5197);
    chk("wrap_addr0", {24'd0, out_addr}, 32'hFC);
    tick();
    in_valid = 1'b0;
    chk("wrap_inst1", out_inst, 32'h1234_5197);
    chk("wrap_addr1", {24'd0, out_addr}, 32'h00);
    tick();

    // reset mid-stream
    out_ready = 1'b0;
    req(OP_ADDI, 5'd2, 5'd3, 5'd0, 32'd7);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_inst", out_inst, 32'd0);
    chk("mid_rst_addr", {24'd0, out_addr}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // start mid-stream
    req(OP_BAD, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    req(OP_ADDI, 5'd2, 5'd3, 5'd0, 32'd7);
    tick();
    in_valid = 1'b0;
    chk("pre_start_cnt", {24'd0, err_cnt}, 32'd1);
    do_start(8'h40);
    chk("mid_start_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_start_cnt", {24'd0, err_cnt}, 32'd0);
    out_ready = 1'b1;
    req(OP_LW, 5'd5, 5'd2, 5'd0, 32'd8);
    tick();
    in_valid = 1'b0;
    chk("mid_start_addr", {24'd0, out_addr}, 32'h40);
    tick();

    // error counter saturation
    req(OP_BAD, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (257) tick();
    in_valid = 1'b0;
    chk("sat_cnt", {24'd0, err_cnt}, 32'd255);
    do_start(8'h00);

    // randomized stream
    for (int n = 0; n < 3000; n++) begin
      automatic int mode = $urandom_range(0, 3);
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 99) == 0);
      base_addr = ADDR_W'($urandom);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      case (mode)
        0: in_imm = $urandom_range(0, 4095);
        1: in_imm = 32'($signed(12'($urandom)));
        2: in_imm = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_F000)
                                                 : 32'($signed(20'($urandom)));
        default: in_imm = $urandom;
      endcase
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
